lsu_mem_port: RTL
=================

Name: lsu_mem_port

Overview:
- Load/store unit on the data-memory side of the writeback path.
- Accepts one load or store request from the execute stage per transaction and drives a req/ack data-memory bus with byte enables.
- For loads, aligns and sign/zero-extends the returned word onto rd, which feeds the memtoreg writeback select.
- For stores, places the data in the correct byte lanes.

Parameters:
- w, 32, data and address width; only 32 supported (4 byte lanes).
- TIMEOUT_CYCLES, 16, watchdog limit in cycles; used only when LSU_TIMEOUT_EN is defined.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- req_valid  in  1  execute stage presents a request.
- req_ready  out  1  unit can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 reserved.
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
- addr  in  w  byte address.
- wdata  in  w  store data, in low bits.
- mem_req  out  1  bus request.
- mem_we  out  1  bus write.
- mem_addr  out  w  word-aligned address ({addr[w-1:2],2'b00}).
- mem_wdata  out  w  lane-replicated store data.
- mem_be  out  4  byte enables.
- mem_ack  in  1  bus completion.
- mem_rdata  in  w  bus read word, valid with mem_ack.
- rd  out  w  formatted load result.
- done  out  1  one-cycle completion pulse (load or store).
- misaligned  out  1  one-cycle fault pulse.

Behaviour:
- Clock and reset: single clock clk; reset is synchronous, active-high, named reset.
- Reset values: state IDLE, req_ready=1, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_be=0, rd=0, done=0, misaligned=0.
- FSM states: IDLE, BUS, RESP.
- IDLE:
  - req_ready=1.
  - Accept on req_valid & req_ready; request fields are registered in the same cycle.
  - Misaligned request (half with addr[0]=1, word with addr[1:0]!=0, or size 11): no bus access; misaligned=1 next cycle; stay IDLE.
  - Otherwise go to BUS.
- BUS:
  - req_ready=0; mem_req=1.
  - mem_we, mem_addr, mem_wdata and mem_be are held stable until mem_ack.
  - On mem_ack: a load captures the formatted mem_rdata into rd. Go to RESP.
- RESP:
  - done=1 for exactly one cycle; then IDLE (req_ready=1 the following cycle).
- Timing and ordering:
  - Latency: accept at cycle T, mem_req high at T+1, ack at cycle A ≥ T+1, done at A+1.
  - mem_ack while mem_req=0 is ignored.
  - Requests are never accepted in BUS or RESP; there are no back-to-back overlapping transactions.
- Byte enables:
  - byte: 4'b0001 << addr[1:0].
  - half: 4'b0011 << addr[1:0].
  - word: 4'b1111.
- Store data: byte replicated ×4; half replicated ×2; word as-is.
- Load format: select lane by addr[1:0], then sign- or zero-extend to w.
- rd holds the last load result. Stores and faults do not modify rd.
- Reset mid-BUS: drop mem_req immediately on the next edge; the outstanding ack is not waited for.

Optional Feature:
- Macro: LSU_TIMEOUT_EN.
- Defined:
  - Adds a cycle counter cleared on entry to BUS.
  - If TIMEOUT_CYCLES cycles pass in BUS with no mem_ack: mem_req drops, new output bus_err (1 bit, reset 0) pulses one cycle, done is not asserted, rd is unchanged, return to IDLE.
  - If mem_ack arrives in the same cycle the limit is reached, the ack wins.
- Not defined: no counter, no bus_err port; BUS waits indefinitely.

Decomposition:
- Package lsu_pkg:
  - size enum (SZ_BYTE, SZ_HALF, SZ_WORD).
  - FSM state enum.
  - Function be_gen(size, addr_lo) returning the 4-bit enable.
  - Function is_misaligned(size, addr_lo).
- Sub-module load_align: combinational; inputs mem_rdata, addr[1:0], size, unsigned; output formatted w-bit value. Instantiated once.

Test Plan:
- Word load: addr=0x100, size=10, ack 3 cycles after mem_req, mem_rdata=0xAAAABBBB -> mem_addr=0x100, mem_be=1111, rd=0xAAAABBBB, done pulses one cycle after ack.
- Signed byte load: addr=0x103, unsigned=0, mem_rdata=0x80FF1122 -> mem_be=1000, rd=0xFFFFFF80. Same with unsigned=1 -> rd=0x00000080.
- Half store: addr=0x206, wdata=0x0000BEEF -> mem_we=1, mem_addr=0x204, mem_be=1100, mem_wdata=0xBEEFBEEF, done one cycle after ack, rd unchanged.
- Misaligned word load at addr=0x101 -> misaligned pulses, mem_req never asserts, req_ready stays 1.
- Reset asserted while in BUS with mem_ack low -> next cycle mem_req=0, req_ready=1, rd=0. A later ack is ignored.
- (LSU_TIMEOUT_EN, TIMEOUT_CYCLES=4) ack withheld -> bus_err pulses after 4 BUS cycles, done stays 0. Separately, ack on the limit cycle -> done=1, bus_err=0.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit memory port.
// Access size encoding, FSM states, byte-enable and store-lane helpers.
package lsu_pkg;

  localparam int LSU_W = 32;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10
  } size_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUS  = 2'b01,
    RESP = 2'b10
  } state_e;

  function automatic logic [3:0] be_gen(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      SZ_BYTE: return 4'b0001 << addr_lo;
      SZ_HALF: return 4'b0011 << addr_lo;
      SZ_WORD: return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  // Size 11 is reserved and always treated as a fault.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return addr_lo[0];
      SZ_WORD: return |addr_lo;
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [LSU_W-1:0] store_rep(input logic [1:0] size, input logic [LSU_W-1:0] data);
    case (size)
      SZ_BYTE: return {4{data[7:0]}};
      SZ_HALF: return {2{data[15:0]}};
      default: return data;
    endcase
  endfunction

endpackage

// File: rtl/lsu_mem_port_if.sv
// Request and data-memory bus bundle for lsu_mem_port.
// bus_err exists only when LSU_TIMEOUT_EN is defined.
interface lsu_mem_port_if #(parameter int w = 32);

  logic         req_valid;
  logic         req_ready;
  logic         req_we;
  logic [1:0]   req_size;
  logic         req_unsigned;
  logic [w-1:0] addr;
  logic [w-1:0] wdata;

  logic         mem_req;
  logic         mem_we;
  logic [w-1:0] mem_addr;
  logic [w-1:0] mem_wdata;
  logic [3:0]   mem_be;
  logic         mem_ack;
  logic [w-1:0] mem_rdata;

  logic [w-1:0] rd;
  logic         done;
  logic         misaligned;
`ifdef LSU_TIMEOUT_EN
  logic         bus_err;
`endif

  modport master (
    input  req_valid, req_we, req_size, req_unsigned, addr, wdata, mem_ack, mem_rdata,
    output req_ready, mem_req, mem_we, mem_addr, mem_wdata, mem_be, rd, done, misaligned
`ifdef LSU_TIMEOUT_EN
    , output bus_err
`endif
  );

  modport slave (
    output req_valid, req_we, req_size, req_unsigned, addr, wdata, mem_ack, mem_rdata,
    input  req_ready, mem_req, mem_we, mem_addr, mem_wdata, mem_be, rd, done, misaligned
`ifdef LSU_TIMEOUT_EN
    , input bus_err
`endif
  );

endinterface

// File: rtl/lsu_mem_port_load_align.sv
// Combinational load formatter: picks the addressed lane of the bus word
// and sign- or zero-extends it to the full data width.
module load_align
  import lsu_pkg::*;
#(
  parameter int w = 32
) (
  input  logic [w-1:0] mem_rdata,
  input  logic [1:0]   addr_lo,
  input  logic [1:0]   size,
  input  logic         load_unsigned,
  output logic [w-1:0] data
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;
  logic        sign_bit;

  always_comb begin
    byte_lane = mem_rdata[{addr_lo, 3'b000} +: 8];
    half_lane = mem_rdata[{addr_lo[1], 4'b0000} +: 16];
    sign_bit  = 1'b0;
    data      = mem_rdata;
    case (size)
      SZ_BYTE: begin
        sign_bit = ~load_unsigned & byte_lane[7];
        data     = {{(w-8){sign_bit}}, byte_lane};
      end
      SZ_HALF: begin
        sign_bit = ~load_unsigned & half_lane[15];
        data     = {{(w-16){sign_bit}}, half_lane};
      end
      default: data = mem_rdata;
    endcase
  end

endmodule

// File: rtl/lsu_mem_port.sv
// Load/store unit data-memory port: one request at a time over a req/ack bus.
// Optional bus watchdog enabled by defining LSU_TIMEOUT_EN (adds bus_err).
module lsu_mem_port
  import lsu_pkg::*;
#(
  parameter int w = 32
`ifdef LSU_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 16
`endif
) (
  input logic            clk,
  input logic            reset,
  lsu_mem_port_if.master bus
);

  state_e       state_q, state_d;
  logic         accept, fault, load_done;
  logic         we_q, unsigned_q, misaligned_q;
  logic [1:0]   size_q, lo_q;
  logic [3:0]   be_q;
  logic [w-1:0] addr_q, wdata_q, rd_q, aligned;

`ifdef LSU_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);
  logic [CW-1:0] cnt_q;
  logic          timeout;
  logic          bus_err_q;
`endif

  load_align #(.w(w)) u_align (
    .mem_rdata     (bus.mem_rdata),
    .addr_lo       (lo_q),
    .size          (size_q),
    .load_unsigned (unsigned_q),
    .data          (aligned)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    fault     = 1'b0;
    load_done = 1'b0;
`ifdef LSU_TIMEOUT_EN
    timeout   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          if (is_misaligned(bus.req_size, bus.addr[1:0])) begin
            fault = 1'b1;
          end else begin
            accept  = 1'b1;
            state_d = BUS;
          end
        end
      end
      BUS: begin
        // An ack on the watchdog's final cycle still completes normally.
        if (bus.mem_ack) begin
          load_done = ~we_q;
          state_d   = RESP;
        end
`ifdef LSU_TIMEOUT_EN
        else if (cnt_q == LIMIT) begin
          timeout = 1'b1;
          state_d = IDLE;
        end
`endif
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      we_q         <= 1'b0;
      unsigned_q   <= 1'b0;
      size_q       <= 2'b00;
      lo_q         <= 2'b00;
      be_q         <= 4'b0000;
      addr_q       <= '0;
      wdata_q      <= '0;
      rd_q         <= '0;
      misaligned_q <= 1'b0;
    end else begin
      misaligned_q <= fault;
      if (accept) begin
        we_q       <= bus.req_we;
        unsigned_q <= bus.req_unsigned;
        size_q     <= bus.req_size;
        lo_q       <= bus.addr[1:0];
        be_q       <= be_gen(bus.req_size, bus.addr[1:0]);
        addr_q     <= {bus.addr[w-1:2], 2'b00};
        wdata_q    <= store_rep(bus.req_size, bus.wdata);
      end
      if (load_done) rd_q <= aligned;
    end
  end

`ifdef LSU_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q     <= '0;
      bus_err_q <= 1'b0;
    end else begin
      bus_err_q <= timeout;
      if (accept)              cnt_q <= '0;
      else if (state_q == BUS) cnt_q <= cnt_q + 1'b1;
    end
  end

  assign bus.bus_err = bus_err_q;
`endif

  assign bus.req_ready  = (state_q == IDLE);
  assign bus.mem_req    = (state_q == BUS);
  assign bus.mem_we     = we_q;
  assign bus.mem_addr   = addr_q;
  assign bus.mem_wdata  = wdata_q;
  assign bus.mem_be     = be_q;
  assign bus.rd         = rd_q;
  assign bus.done       = (state_q == RESP);
  assign bus.misaligned = misaligned_q;

endmodule
